// File: rtl/id_reg_pkg.sv
// Shared RV32I decode constants and helpers for the ID pipeline register and
// the immediate generator.
package id_reg_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;

    localparam logic [31:0] NOP_ENC = 32'h0000_0013;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } id_state_e;

    // Only U-type and JAL have no rs1 field; unknown opcodes are treated as
    // readers so a hazard is never missed.
    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return opc inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    endfunction

endpackage

// File: rtl/id_imm_gen.sv
// Combinational RV32I immediate generator (I/S/B/U/J formats, sign from
// insn[31]); shared with the branch unit.
module id_imm_gen
    import id_reg_pkg::*;
(
    input  logic [31:0] insn,
    output logic [31:0] imm
);

    logic [6:0] opc;
    assign opc = insn[6:0];

    always_comb begin
        unique case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                imm = {{20{insn[31]}}, insn[31:20]};
            OPC_STORE:
                imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            OPC_BRANCH:
                imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {insn[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/id_reg.sv
// Instruction-decode pipeline register with load-use stall and flush.
// Optional performance counters are enabled by defining ID_PERF_CNT_EN.
module id_reg
    import id_reg_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSN_W   = 32,
    parameter logic [INSN_W-1:0] NOP_INSN = NOP_ENC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_en,
    input  logic                  if_en,
    input  logic [ADDR_W-1:0]     if_pc,
    input  logic [INSN_W-1:0]     if_insn,
    input  logic                  flush,
    output logic                  id_stall,
    output logic                  id_valid,
    output logic [ADDR_W-1:0]     id_pc,
    output logic [INSN_W-1:0]     id_insn,
    output logic [6:0]            id_opcode,
    output logic [2:0]            id_funct3,
    output logic [6:0]            id_funct7,
    output logic [REG_ADDR_W-1:0] id_rs1_addr,
    output logic [REG_ADDR_W-1:0] id_rs2_addr,
    output logic [REG_ADDR_W-1:0] id_rd_addr,
    output logic [31:0]           id_imm,
    output logic                  id_is_load
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]           id_stall_cnt,
    output logic [31:0]           id_flush_cnt
`endif
);

    id_state_e             state_q, state_d;
    logic                  valid_d;
    logic [ADDR_W-1:0]     pc_d;
    logic [INSN_W-1:0]     insn_d;
    logic [31:0]           imm_d;
    logic [31:0]           if_imm;
    logic [6:0]            if_opc;
    logic [REG_ADDR_W-1:0] if_rs1, if_rs2;
    logic                  hazard;

    id_imm_gen u_imm_gen (
        .insn (if_insn[31:0]),
        .imm  (if_imm)
    );

    // Decoded fields are slices of the registered instruction, so a bubble
    // automatically presents the NOP decode.
    assign id_opcode   = id_insn[6:0];
    assign id_rd_addr  = id_insn[11:7];
    assign id_funct3   = id_insn[14:12];
    assign id_rs1_addr = id_insn[19:15];
    assign id_rs2_addr = id_insn[24:20];
    assign id_funct7   = id_insn[31:25];
    assign id_is_load  = id_valid && (id_opcode == OPC_LOAD);

    assign if_opc = if_insn[6:0];
    assign if_rs1 = if_insn[19:15];
    assign if_rs2 = if_insn[24:20];

    // In BUBBLE the ID slot is never a valid load, so the state term only
    // makes the one-cycle stall explicit.
    assign hazard = (state_q == ST_RUN) && id_is_load && (id_rd_addr != '0) && if_en &&
                    ((uses_rs1(if_opc) && (if_rs1 == id_rd_addr)) ||
                     (uses_rs2(if_opc) && (if_rs2 == id_rd_addr)));

    assign id_stall = hazard && !flush;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = ST_RUN;
        valid_d = 1'b0;
        pc_d    = '0;
        insn_d  = NOP_INSN;
        imm_d   = '0;
        if (!cpu_en || flush) begin
            state_d = ST_RUN;
        end else if (hazard) begin
            state_d = ST_BUBBLE;
        end else if (if_en) begin
            valid_d = 1'b1;
            pc_d    = if_pc;
            insn_d  = if_insn;
            imm_d   = if_imm;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q  <= ST_RUN;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_insn  <= NOP_INSN;
            id_imm   <= '0;
        end else begin
            state_q  <= state_d;
            id_valid <= valid_d;
            id_pc    <= pc_d;
            id_insn  <= insn_d;
            id_imm   <= imm_d;
        end
    end

`ifdef ID_PERF_CNT_EN
    // Counters survive cpu_en low; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_stall_cnt <= '0;
            id_flush_cnt <= '0;
        end else begin
            if (id_stall) id_stall_cnt <= id_stall_cnt + 32'd1;
            if (flush)    id_flush_cnt <= id_flush_cnt + 32'd1;
        end
    end
`else
    // Performance counters are compiled out in this build.
`endif

endmodule

// File: doc/id_reg.md
Name: id_reg

Overview:
- Instruction-decode pipeline register directly downstream of the fetch stage.
- Captures the fetched PC/instruction pair and registers the decoded RV32I fields for the execute stage.
- Detects load-use hazards against the instruction it currently holds, stalls fetch for one cycle, and inserts a bubble.
- Kills its contents on a taken-branch flush.

Parameters:
- ADDR_W, 32, PC width in bits.
- INSN_W, 32, instruction width in bits.
- NOP_INSN, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_en  in  1  core enable; low behaves as a synchronous clear to bubble.
- if_en  in  1  fetch output valid.
- if_pc  in  ADDR_W  PC of the fetched instruction.
- if_insn  in  INSN_W  fetched instruction.
- flush  in  1  taken branch resolved downstream; kill ID contents.
- id_stall  out  1  combinational; fetch holds if_pc/if_insn this cycle.
- id_valid  out  1  registered; ID holds a live instruction.
- id_pc  out  ADDR_W  registered PC.
- id_insn  out  INSN_W  registered raw instruction.
- id_opcode  out  7  insn[6:0].
- id_funct3  out  3  insn[14:12].
- id_funct7  out  7  insn[31:25].
- id_rs1_addr  out  5  insn[19:15].
- id_rs2_addr  out  5  insn[24:20].
- id_rd_addr  out  5  insn[11:7].
- id_imm  out  32  sign-extended immediate.
- id_is_load  out  1  opcode == LOAD and id_valid.

Behaviour:
- Reset and cpu_en low: on the clock edge, load the bubble.
  - id_valid=0, id_insn=NOP_INSN, id_pc=0, id_imm=0.
  - Decoded fields take the NOP decode: opcode=7'h13, all others 0.
  - id_is_load=0, state=RUN.
- States:
  - RUN: normal capture.
  - BUBBLE: one-cycle inserted NOP after a hazard.
- Hazard condition (combinational), all of the following true:
  - id_valid and id_is_load and id_rd_addr != 0.
  - if_en.
  - if_insn uses rs1 with rs1 == id_rd_addr, or uses rs2 with rs2 == id_rd_addr.
  - rs1 users: all opcodes except LUI, AUIPC, JAL.
  - rs2 users: BRANCH, STORE, OP.
- id_stall = hazard and not flush. Asserted in the same cycle the hazard is seen.
- Priority per edge: reset > !cpu_en > flush > hazard > capture.
  - flush: load bubble, state=RUN. Any pending stall is cancelled.
  - hazard: load bubble, state=BUBBLE. Fetch holds, so the same if_insn is presented next cycle.
  - capture: register if_pc, if_insn and the decode; id_valid=if_en. If if_en=0, load bubble instead. state=RUN.
- BUBBLE -> RUN unconditionally after one cycle. The instruction in ID is now a non-load bubble, so the hazard clears and the held instruction is captured at the next edge.
- Latency: if_insn to decoded outputs is 1 cycle; 2 cycles on a load-use stall.
- Immediate generation, sign bit always insn[31]:
  - I-type (LOAD, OP-IMM, JALR): 12-bit.
  - S-type: 12-bit.
  - B-type: 13-bit, LSB 0.
  - U-type: insn[31:12]<<12.
  - J-type: 21-bit, LSB 0.
  - R-type/other: 0.
- Back-to-back loads: each dependent consumer sees exactly one bubble.
- Load to x0 never stalls.

Optional Feature:
- Macro: ID_PERF_CNT_EN.
- Defined: adds two 32-bit outputs, id_stall_cnt and id_flush_cnt.
  - id_stall_cnt increments on each cycle id_stall=1; id_flush_cnt increments on each flush edge.
  - Both wrap modulo 2^32 and clear on reset only (not on cpu_en low).
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared define.v holds: opcode constants (LOAD, STORE, BRANCH, JAL, JALR, OP, OP_IMM, LUI, AUIPC), NOP encoding, register-address width 5, state encodings RUN/BUBBLE.
- One sub-module: id_imm_gen, a combinational insn -> 32-bit immediate generator. It is reused later by the branch unit.

Test Plan:
1. Reset asserted 2 cycles with if_insn=32'h00500093 -> id_valid=0, id_insn=32'h00000013, id_imm=0. After release, next edge: id_imm=5, id_rd_addr=1, id_valid=1.
2. ID holds lw x5,0(x1), if_insn=add x6,x5,x2 -> id_stall=1 same cycle. Next edge: bubble (id_valid=0). Following edge: id_insn=add, id_rs1_addr=5, id_stall=0.
3. ID holds lw x0,0(x1), dependent add x6,x0,x2 -> id_stall stays 0; add is captured next edge.
4. Hazard and flush in the same cycle -> id_stall=0; bubble loaded; state=RUN; no extra stall cycle.
5. Immediate checks:
   - if_insn=32'hFE000EE3 (beq, offset -4) -> id_imm=32'hFFFFFFFC.
   - 32'h123452B7 (lui) -> id_imm=32'h12345000.
   - 32'hFFDFF06F (jal -4) -> id_imm=32'hFFFFFFFC.
6. With ID_PERF_CNT_EN: 3 load-use stalls and 2 flushes -> id_stall_cnt=3, id_flush_cnt=2. Then cpu_en low for 1 cycle -> counts unchanged.
